// File: rtl/split_eval_pkg.sv
// Shared encodings for the split evaluator: evaluation modes and FSM states.
package split_eval_pkg;

    localparam int MODE_CONST = 0;
    localparam int MODE_BOUND = 1;
    localparam int MODE_SUM   = 2;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_REPORT  = 1'b1
    } state_t;

endpackage

// File: rtl/split_seen_bitmap.sv
// Per-variable seen bitmap: test-and-set returning the prior bit, with synchronous clear.
module split_seen_bitmap #(
    parameter int NUM_VARS = 150,
    parameter int IDX_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             set_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic             prior_o
);

    logic [NUM_VARS-1:0] bits_q;
    logic [NUM_VARS-1:0] bits_d;

    // Index decode by compare keeps out-of-range indices harmless (prior reads 0, nothing set).
    always_comb begin
        prior_o = 1'b0;
        bits_d  = bits_q;
        for (int i = 0; i < NUM_VARS; i++) begin
            if (32'(idx_i) == i) begin
                prior_o = bits_q[i];
                if (set_i) bits_d[i] = 1'b1;
            end
        end
        if (clr_i) bits_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) bits_q <= '0;
        else     bits_q <= bits_d;
    end

endmodule

// File: rtl/split_eval_seq.sv
// Collects one variable assignment beat by beat, then reports the constraint verdict
// and a malformed-assignment flag until the consumer takes it.
//   state      | meaning
//   ST_COLLECT | accepting beats, accumulating flags / evaluator
//   ST_REPORT  | verdict held on x/err until out_ready
module split_eval_seq
    import split_eval_pkg::*;
#(
    parameter int              NUM_VARS = 150,
    parameter int              DATA_W   = 16,
    parameter int              IDX_W    = 8,
    parameter int              MODE     = 0,
    parameter logic [DATA_W-1:0] LIMIT  = '1,
    parameter int              SUM_W    = 24,
    parameter logic [SUM_W-1:0] TARGET  = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IDX_W-1:0]  in_idx,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              x,
    output logic              err
);

    localparam int CNT_W = $clog2(NUM_VARS + 1);

    state_t            state_q, state_d;
    logic              range_q, dup_q, ok_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [SUM_W-1:0]  sum_q;

    logic accept, done, in_range, prior, fresh;
    logic err_w, verdict;

    assign accept   = in_valid && (state_q == ST_COLLECT);
    assign done     = (state_q == ST_REPORT) && out_ready;
    assign in_range = 32'(in_idx) < NUM_VARS;
    assign fresh    = accept && in_range && !prior;

    split_seen_bitmap #(
        .NUM_VARS (NUM_VARS),
        .IDX_W    (IDX_W)
    ) u_seen (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (done),
        .set_i   (fresh),
        .idx_i   (in_idx),
        .prior_o (prior)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_COLLECT;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_COLLECT: if (accept && in_last) state_d = ST_REPORT;
            ST_REPORT:  if (out_ready)         state_d = ST_COLLECT;
            default:                           state_d = ST_COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || done) begin
            range_q <= 1'b0;
            dup_q   <= 1'b0;
            ok_q    <= 1'b1;
            cnt_q   <= '0;
            sum_q   <= '0;
        end else if (accept) begin
            if (!in_range) begin
                range_q <= 1'b1;
            end else if (prior) begin
                dup_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
                if (in_data > LIMIT) ok_q <= 1'b0;
                sum_q <= sum_q + SUM_W'(in_data);
            end
        end
    end

    assign err_w = range_q | dup_q | (cnt_q != CNT_W'(NUM_VARS));

    always_comb begin
        verdict = 1'b0;
        case (MODE)
            MODE_CONST: verdict = 1'b1;
            MODE_BOUND: verdict = ok_q;
            MODE_SUM:   verdict = (sum_q == TARGET);
            default:    verdict = 1'b0;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ST_COLLECT);
        out_valid = (state_q == ST_REPORT);
        err       = 1'b0;
        x         = 1'b0;
        if (state_q == ST_REPORT) begin
            err = err_w;
            x   = !err_w && verdict;
        end
    end

endmodule
